hv_bist_seq_ctrl: RTL and testbench

Sequencer for the HV-side built-in self-test. On a BIST request it enables the analog BIST engine (hv_abist) and waits for the engine's lbist-enable hand-off. It then launches logic BIST and collects the pass/fail results of both phases, with timeouts, optional retries and an abort path. It sits between the HV register/FSM layer (request, result readback) and hv_abist plus the logic-BIST engine.

---
 rtl/hv_bist_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_hv_bist_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_bist_seq_ctrl.sv
// hv_bist_seq_ctrl
// HV-side BIST sequencer. It enables hv_abist, waits for the lbist-enable
// hand-off, launches logic BIST, and collects the results of both phases.
// Both phases have timeouts, and an abort path ends a run early.
//
// Optional build macro: HV_BIST_RETRY_EN
//   When it is defined, a failed run is repeated through a GAP state, up to
//   RETRY_NUM times. When it is undefined, the GAP state and the retry logic
//   are not built, and o_retry_cnt is tied to 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for i_bist_req, o_bist_en low
// ABIST   | hv_abist enabled, waiting for i_lbist_en or analog timeout
// LBIST   | logic BIST launched, waiting for i_lbist_done or timeout
// EVAL    | one cycle to decide pass / retry / fail
// GAP     | o_bist_en held low so hv_abist restarts cleanly (retry only)
// DONE    | one-cycle completion pulse, then back to IDLE
module hv_bist_seq_ctrl #(
  parameter int CLK_M        = 48,
  parameter int ABIST_TMO_US = 100,
  parameter int LBIST_TMO_US = 20,
  parameter int GAP_CYC      = 4,
  parameter int RETRY_NUM    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_bist_req,
  input  logic       i_bist_abort,
  output logic       o_bist_en,
  input  logic       i_lbist_en,
  input  logic [5:0] i_abist_status,
  output logic       o_lbist_start,
  input  logic       i_lbist_done,
  input  logic       i_lbist_pass,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic       o_abort,
  output logic [7:0] o_fail_vec,
  output logic [1:0] o_retry_cnt
);

  localparam int ABIST_TMO_CYC = ABIST_TMO_US * CLK_M;
  localparam int LBIST_TMO_CYC = LBIST_TMO_US * CLK_M;
  localparam int CNT_MAX_AL    = (ABIST_TMO_CYC > LBIST_TMO_CYC) ? ABIST_TMO_CYC : LBIST_TMO_CYC;
  localparam int CNT_MAX       = (CNT_MAX_AL > GAP_CYC) ? CNT_MAX_AL : GAP_CYC;
  localparam int CNT_W         = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ABIST_LAST = CNT_W'(ABIST_TMO_CYC - 1);
  localparam logic [CNT_W-1:0] LBIST_LAST = CNT_W'(LBIST_TMO_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ABIST = 3'd1;
  localparam logic [2:0] S_LBIST = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef HV_BIST_RETRY_EN
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(RETRY_NUM);
`endif

  // A zero-length gap, or a retry limit that does not fit the 2-bit
  // o_retry_cnt, would break the retry sequence.
  if (GAP_CYC < 1 || RETRY_NUM < 0 || RETRY_NUM > 3) begin : g_param_check
    $error("hv_bist_seq_ctrl: GAP_CYC must be >= 1 and RETRY_NUM must be 0..3");
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       fail_vec_q, fail_vec_d;
  logic             abort_q, abort_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             bist_en_q, bist_en_d;
  logic             lbist_start_q, lbist_start_d;
  logic             busy_q, busy_d;
  logic             abort_go;
  logic             timed;
`ifdef HV_BIST_RETRY_EN
  logic [1:0]       retry_cnt_q, retry_cnt_d;
`endif

  // Next-state, result latching and registered-output decode.
  always_comb begin
    state_d    = state_q;
    fail_vec_d = fail_vec_q;
    abort_d    = abort_q;
    pass_d     = pass_q;
    abort_go   = 1'b0;
`ifdef HV_BIST_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A request that arrives together with an abort is dropped.
        if (i_bist_req && !i_bist_abort) begin
          state_d    = S_ABIST;
          fail_vec_d = 8'h00;
          abort_d    = 1'b0;
          pass_d     = 1'b0;
`ifdef HV_BIST_RETRY_EN
          retry_cnt_d = 2'd0;
`endif
        end
      end
      S_ABIST: begin
        if (i_bist_abort) begin
          abort_go = 1'b1;
        end else if (i_lbist_en) begin
          fail_vec_d[5:0] = i_abist_status;
          state_d         = S_LBIST;
        end else if (cnt_q == ABIST_LAST) begin
          fail_vec_d[5:0] = i_abist_status;
          fail_vec_d[6]   = 1'b1;
          state_d         = S_EVAL;
        end
      end
      S_LBIST: begin
        // When done and the timeout land in the same cycle, the reported
        // result from done is used.
        if (i_bist_abort) begin
          abort_go = 1'b1;
        end else if (i_lbist_done) begin
          fail_vec_d[7] = ~i_lbist_pass;
          state_d       = S_EVAL;
        end else if (cnt_q == LBIST_LAST) begin
          fail_vec_d[7] = 1'b1;
          state_d       = S_EVAL;
        end
      end
      S_EVAL: begin
        if (i_bist_abort) begin
          abort_go = 1'b1;
        end else if (fail_vec_q == 8'h00) begin
          state_d = S_DONE;
`ifdef HV_BIST_RETRY_EN
        end else if (retry_cnt_q < RETRY_MAX) begin
          state_d     = S_GAP;
          retry_cnt_d = retry_cnt_q + 2'd1;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
`ifdef HV_BIST_RETRY_EN
      S_GAP: begin
        if (i_bist_abort) begin
          abort_go = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          fail_vec_d = 8'h00;
          state_d    = S_ABIST;
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An abort keeps whatever partial result has been latched so far.
    if (abort_go) begin
      state_d = S_DONE;
      abort_d = 1'b1;
    end

    if (state_d == S_DONE && state_q != S_DONE) begin
      pass_d = (fail_vec_d == 8'h00) && !abort_d;
    end

`ifdef HV_BIST_RETRY_EN
    timed = (state_q == S_ABIST) || (state_q == S_LBIST) || (state_q == S_GAP);
`else
    timed = (state_q == S_ABIST) || (state_q == S_LBIST);
`endif
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (timed) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs are decoded from the next state so that they line up with the
    // state register.
    bist_en_d     = (state_d == S_ABIST) || (state_d == S_LBIST);
    lbist_start_d = (state_d == S_LBIST) && (state_q != S_LBIST);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  // State, counter, result and output registers; an async reset clears everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      fail_vec_q    <= 8'h00;
      abort_q       <= 1'b0;
      pass_q        <= 1'b0;
      done_q        <= 1'b0;
      bist_en_q     <= 1'b0;
      lbist_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fail_vec_q    <= fail_vec_d;
      abort_q       <= abort_d;
      pass_q        <= pass_d;
      done_q        <= done_d;
      bist_en_q     <= bist_en_d;
      lbist_start_q <= lbist_start_d;
      busy_q        <= busy_d;
    end
  end

`ifdef HV_BIST_RETRY_EN
  // Retry counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      retry_cnt_q <= 2'd0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign o_retry_cnt = retry_cnt_q;
`else
  assign o_retry_cnt = 2'd0;
`endif

  assign o_bist_en     = bist_en_q;
  assign o_lbist_start = lbist_start_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_pass        = pass_q;
  assign o_abort       = abort_q;
  assign o_fail_vec    = fail_vec_q;

endmodule

// File: tb/tb_hv_bist_seq_ctrl.sv
// Testbench for hv_bist_seq_ctrl: directed scenarios plus randomized runs.
// Each run is checked against a run-level timing/result model.
module tb_hv_bist_seq_ctrl;

  localparam int CLK_M        = 48;
  localparam int ABIST_TMO_US = 100;
  localparam int LBIST_TMO_US = 20;
  localparam int GAP_CYC      = 4;
  localparam int RETRY_NUM    = 2;
  localparam int ABIST_TMO    = ABIST_TMO_US * CLK_M;
  localparam int LBIST_TMO    = LBIST_TMO_US * CLK_M;
`ifdef HV_BIST_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_bist_req;
  logic       i_bist_abort;
  logic       o_bist_en;
  logic       i_lbist_en;
  logic [5:0] i_abist_status;
  logic       o_lbist_start;
  logic       i_lbist_done;
  logic       i_lbist_pass;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic       o_abort;
  logic [7:0] o_fail_vec;
  logic [1:0] o_retry_cnt;

  hv_bist_seq_ctrl #(
    .CLK_M(CLK_M), .ABIST_TMO_US(ABIST_TMO_US), .LBIST_TMO_US(LBIST_TMO_US),
    .GAP_CYC(GAP_CYC), .RETRY_NUM(RETRY_NUM)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bist_req(i_bist_req), .i_bist_abort(i_bist_abort),
    .o_bist_en(o_bist_en), .i_lbist_en(i_lbist_en), .i_abist_status(i_abist_status),
    .o_lbist_start(o_lbist_start), .i_lbist_done(i_lbist_done), .i_lbist_pass(i_lbist_pass),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_abort(o_abort),
    .o_fail_vec(o_fail_vec), .o_retry_cnt(o_retry_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-attempt environment behaviour: a = cycles until i_lbist_en (0 = never),
  // b = cycles after lbist start until done (0 = never), st = status, p = pass.
  int         a_arr[3];
  int         b_arr[3];
  logic [5:0] st_arr[3];
  logic       p_arr[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_att(input int i, input int a, input int b, input logic [5:0] st, input logic p);
    a_arr[i]  = a;
    b_arr[i]  = b;
    st_arr[i] = st;
    p_arr[i]  = p;
  endtask

  function automatic logic [15:0] all_outs();
    return {o_busy, o_bist_en, o_done, o_pass, o_abort, o_lbist_start, o_retry_cnt, o_fail_vec};
  endfunction

  // Reactive model of hv_abist and the logic-BIST engine.
  initial begin : env
    int   att;
    int   en_cnt;
    int   lc;
    int   ai;
    logic en_prev;
    att = 0; en_cnt = 0; lc = 0; en_prev = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!o_busy) begin
        att = 0; en_cnt = 0; lc = 0;
      end else if (!o_bist_en) begin
        if (en_prev) att++;
        en_cnt = 0; lc = 0;
      end else begin
        en_cnt++;
      end
      en_prev = o_bist_en;
      if (o_lbist_start) lc = 1;
      else if (lc != 0) lc++;
      ai = (att < 3) ? att : 2;
      i_abist_status = st_arr[ai];
      i_lbist_en     = o_bist_en && (a_arr[ai] != 0) && (en_cnt >= a_arr[ai]);
      i_lbist_done   = (lc != 0) && (b_arr[ai] != 0) && (lc == b_arr[ai]);
      i_lbist_pass   = p_arr[ai];
    end
  end

  function automatic int att_dur(input int i);
    if (a_arr[i] == 0) return ABIST_TMO;
    return a_arr[i] + ((b_arr[i] == 0) ? LBIST_TMO : b_arr[i]);
  endfunction

  // Runs one request. Expected results come from the run-level model below.
  // abort_t is the edge, counted from the accepting edge, at which an abort is
  // sampled (0 = none).
  task automatic run_case(input string name, input int abort_t, input bit mid_req);
    int t, da, db, rc, starts, low, exp_t, k, done_k, n_done, n_start, n_low, midreq_k;
    bit lb, ex_pass, ex_abort;
    logic [7:0] f, ex_fv, s_fv;
    logic s_pass, s_abort, s_en;
    logic [1:0] s_rc;
    t = 0; rc = 0; starts = 0; low = 0; exp_t = 0;
    ex_fv = 8'h00; ex_pass = 1'b0; ex_abort = 1'b0;
    for (int att = 0; att <= RETRY_NUM; att++) begin
      f = {2'b00, st_arr[att]};
      if (a_arr[att] == 0) begin
        da = ABIST_TMO; db = 0; lb = 1'b0; f[6] = 1'b1;
      end else begin
        da = a_arr[att]; lb = 1'b1;
        if (b_arr[att] == 0) begin
          db = LBIST_TMO; f[7] = 1'b1;
        end else begin
          db = b_arr[att]; f[7] = ~p_arr[att];
        end
      end
      if (att == 0 && abort_t > 0 && abort_t <= da + db + 1) begin
        ex_fv = 8'h00;
        if (abort_t > da) ex_fv[6:0] = f[6:0];
        if (lb && abort_t > da + db) ex_fv[7] = f[7];
        if (lb && abort_t > da) starts = 1;
        low = (abort_t > da + db) ? 2 : 1;
        exp_t = abort_t; ex_abort = 1'b1; ex_pass = 1'b0;
        break;
      end
      starts += int'(lb);
      low += 1;
      if (f != 8'h00 && RETRY_ON && rc < RETRY_NUM) begin
        rc++;
        low += GAP_CYC;
        t += da + db + 1 + GAP_CYC;
      end else begin
        ex_fv = f; exp_t = t + da + db + 1; low += 1; ex_pass = (f == 8'h00);
        break;
      end
    end
    midreq_k = mid_req ? int'($urandom_range(0, exp_t)) : -1;

    i_bist_abort = 1'b0;
    i_bist_req = 1'b1;
    @(posedge i_clk);
    #1;
    i_bist_req = 1'b0;
    k = 0; done_k = -1; n_done = 0; n_start = 0; n_low = 0;
    s_fv = 8'h00; s_pass = 1'b0; s_abort = 1'b0; s_en = 1'b0; s_rc = 2'd0;
    while (k < exp_t + 20) begin
      if (o_done) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k; s_fv = o_fail_vec; s_pass = o_pass; s_abort = o_abort;
          s_en = o_bist_en; s_rc = o_retry_cnt;
        end
      end
      if (o_lbist_start) n_start++;
      if (o_busy && !o_bist_en) n_low++;
      if (done_k >= 0 && k >= done_k + 2) break;
      i_bist_abort = (k == abort_t - 1);
      i_bist_req   = (k == midreq_k);
      @(posedge i_clk);
      #1;
      k++;
    end
    i_bist_abort = 1'b0;
    i_bist_req   = 1'b0;
    chk({name, ".done_seen"}, 32'(done_k >= 0), 32'd1);
    chk({name, ".done_cyc"}, 32'(done_k), 32'(exp_t));
    chk({name, ".done_pulses"}, 32'(n_done), 32'd1);
    chk({name, ".fail_vec"}, 32'(s_fv), 32'(ex_fv));
    chk({name, ".pass"}, 32'(s_pass), 32'(ex_pass));
    chk({name, ".abort"}, 32'(s_abort), 32'(ex_abort));
    chk({name, ".retry_cnt"}, 32'(s_rc), 32'(rc));
    chk({name, ".lbist_starts"}, 32'(n_start), 32'(starts));
    chk({name, ".en_low_cyc"}, 32'(n_low), 32'(low));
    chk({name, ".en_at_done"}, 32'(s_en), 32'd0);
    chk({name, ".hold"}, {22'd0, o_busy, o_pass, o_fail_vec}, {22'd0, 1'b0, ex_pass, ex_fv});
  endtask

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int abort_t;
    i_rst = 1'b1; i_bist_req = 1'b0; i_bist_abort = 1'b0;
    for (int i = 0; i < 3; i++) set_att(i, 10, 10, 6'h00, 1'b1);
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_state", 32'(all_outs()), 32'd0);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;

    // Clean pass run.
    set_att(0, 3800, 100, 6'h00, 1'b1);
    run_case("pass", 0, 1'b0);

    // Analog timeout, status 0x04 -> 0x44.
    set_att(0, 0, 10, 6'h04, 1'b1);
    for (int i = 1; i < 3; i++) set_att(i, 0, 10, 6'h04, 1'b1);
    run_case("abist_tmo", 0, 1'b0);

    // Logic BIST reports fail, then logic BIST never finishes.
    for (int i = 0; i < 3; i++) set_att(i, 30, 40, 6'h00, 1'b0);
    run_case("lbist_fail", 0, 1'b0);
    for (int i = 0; i < 3; i++) set_att(i, 30, 0, 6'h00, 1'b1);
    run_case("lbist_tmo", 0, 1'b0);

    // Two failing attempts followed by a clean one.
    set_att(0, 20, 10, 6'h01, 1'b1);
    set_att(1, 25, 10, 6'h01, 1'b1);
    set_att(2, 30, 10, 6'h00, 1'b1);
    run_case("retry", 0, 1'b0);

    // Abort at cycle 100 of ABIST, with a stray request during the run.
    for (int i = 0; i < 3; i++) set_att(i, 3800, 100, 6'h00, 1'b1);
    run_case("abort", 100, 1'b1);

    // A request together with an abort in IDLE is dropped.
    i_bist_req = 1'b1; i_bist_abort = 1'b1;
    @(posedge i_clk);
    #1;
    i_bist_req = 1'b0; i_bist_abort = 1'b0;
    chk("idle_req_abort", {29'd0, o_busy, o_bist_en, o_done}, 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("idle_req_abort_later", {29'd0, o_busy, o_bist_en, o_done}, 32'd0);

    // Reset while in LBIST.
    for (int i = 0; i < 3; i++) set_att(i, 50, 0, 6'h00, 1'b1);
    i_bist_req = 1'b1;
    @(posedge i_clk);
    #1;
    i_bist_req = 1'b0;
    repeat (60) @(posedge i_clk);
    #1;
    chk("pre_reset_lbist", {30'd0, o_busy, o_bist_en}, 32'd3);
    #2;
    i_rst = 1'b1;
    #1;
    chk("async_reset", 32'(all_outs()), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("post_reset_idle", 32'(all_outs()), 32'd0);
    for (int i = 0; i < 3; i++) set_att(i, 20, 30, 6'h00, 1'b1);
    run_case("after_reset", 0, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 3; i++) begin
        set_att(i,
                ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 200)),
                ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 150)),
                ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom()),
                ($urandom_range(0, 3) != 0));
      end
      abort_t = 0;
      if ($urandom_range(0, 4) == 0) abort_t = int'($urandom_range(1, att_dur(0) + 1));
      run_case($sformatf("rnd%0d", r), abort_t, ($urandom_range(0, 1) == 1));
      repeat (2) @(posedge i_clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
